// File: rtl/lag_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lag_meter_pkg
//  Description : Shared types and constants for the lag_meter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package lag_meter_pkg;

    // Depth of the per-channel metastability synchroniser.
    localparam int SYNC_DEPTH = 2;

    // Width of the per-channel statistics sample counter.
    localparam int STAT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lag_meter_sync.sv
`default_nettype none
// ============================================================================
//  Module      : lag_meter_sync
//  Description : One sensor channel front end: polarity normalisation,
//                synchroniser and inactive-to-active edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module lag_meter_sync
    import lag_meter_pkg::*;
#(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic sensor_raw,
    output logic rise
);

    // Normalised to active-high before synchronising so that the reset value
    // of the flops always means "inactive" and cannot fake an edge.
    logic                  active_raw;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    assign active_raw = ACT_LOW ? ~sensor_raw : sensor_raw;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], active_raw};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/lag_meter.sv
`default_nettype none
// ============================================================================
//  Module      : lag_meter
//  Description : Measures per-channel latency from a start pulse to the first
//                active edge of each photosensor, with abort on timeout.
//                Optional macro LAG_METER_STATS_EN adds min/max/sum/count
//                statistics per channel with a clear_stats input.
//  Revision    : 1.0 - initial release
// ============================================================================
module lag_meter
    import lag_meter_pkg::*;
#(
    parameter int              CHANNELS       = 2,
    parameter int              CNT_W          = 24,
    parameter longint unsigned TIMEOUT        = (64'd1 << CNT_W) - 64'd1,
    parameter bit              SENSOR_ACT_LOW = 1'b1
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [CHANNELS-1:0]             sensor,
`ifdef LAG_METER_STATS_EN
    input  logic                            clear_stats,
    output logic [CHANNELS*CNT_W-1:0]       lat_min,
    output logic [CHANNELS*CNT_W-1:0]       lat_max,
    output logic [CHANNELS*(CNT_W+16)-1:0]  lat_sum,
    output logic [CHANNELS*16-1:0]          lat_cnt,
`endif
    output logic                            busy,
    output logic [CHANNELS-1:0]             done,
    output logic [CHANNELS-1:0]             timeout,
    output logic [CHANNELS*CNT_W-1:0]       latency
);

    localparam logic [CNT_W-1:0] TMO_VAL = TIMEOUT[CNT_W-1:0];

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    counter_q;
    logic [CHANNELS-1:0] captured_q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] new_cap;
    logic                all_cap;
    logic                at_limit;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            lag_meter_sync #(
                .ACT_LOW    (SENSOR_ACT_LOW)
            ) u_sync (
                .clk_sys    (clk_sys),
                .reset_n    (reset_n),
                .sensor_raw (sensor[g]),
                .rise       (rise[g])
            );
        end
    endgenerate

    // Only the first edge of an uncaptured channel during MEASURE counts.
    assign new_cap  = (state_q == ST_MEASURE) ? (rise & ~captured_q) : '0;
    // An edge arriving in the timeout cycle still counts as captured.
    assign all_cap  = &(captured_q | new_cap);
    assign at_limit = (counter_q == TMO_VAL);

    // State register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pulse outputs; REPORT is a single-cycle state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = '0;
        timeout = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                busy = 1'b1;
                if (all_cap || at_limit) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                busy    = 1'b1;
                done    = captured_q;
                timeout = ~captured_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Cycle counter: reads k in the k-th cycle after start, saturates at max.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE:    counter_q <= start ? CNT_W'(1) : '0;
                ST_MEASURE: begin
                    if (counter_q != '1) begin
                        counter_q <= counter_q + CNT_W'(1);
                    end
                end
                default:    counter_q <= '0;
            endcase
        end
    end

    // Capture flags and latched latencies; results persist until overwritten.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            captured_q <= '0;
            latency    <= '0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                captured_q <= '0;
            end else begin
                captured_q <= captured_q | new_cap;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (new_cap[i]) begin
                    latency[i*CNT_W +: CNT_W] <= counter_q;
                end
            end
        end
    end

`ifdef LAG_METER_STATS_EN
    localparam int SUM_W = CNT_W + 16;

    // Per-channel statistics, updated once per report; frozen at full count.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
            lat_cnt <= '0;
        end else if (clear_stats) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
            lat_cnt <= '0;
        end else if (state_q == ST_REPORT) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (captured_q[i] && (lat_cnt[i*STAT_CNT_W +: STAT_CNT_W] != '1)) begin
                    if (latency[i*CNT_W +: CNT_W] < lat_min[i*CNT_W +: CNT_W]) begin
                        lat_min[i*CNT_W +: CNT_W] <= latency[i*CNT_W +: CNT_W];
                    end
                    if (latency[i*CNT_W +: CNT_W] > lat_max[i*CNT_W +: CNT_W]) begin
                        lat_max[i*CNT_W +: CNT_W] <= latency[i*CNT_W +: CNT_W];
                    end
                    lat_sum[i*SUM_W +: SUM_W] <= lat_sum[i*SUM_W +: SUM_W]
                                                 + SUM_W'(latency[i*CNT_W +: CNT_W]);
                    lat_cnt[i*STAT_CNT_W +: STAT_CNT_W] <= lat_cnt[i*STAT_CNT_W +: STAT_CNT_W]
                                                           + STAT_CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lag_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lag_meter
//  Description : Self-checking bench for lag_meter: directed scenarios plus
//                randomized sensor traces against a trace-level latency model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lag_meter;

    localparam int CHANNELS = 2;
    localparam int CNT_W    = 24;
    localparam int TIMEOUT  = 100;
    localparam int MAXC     = TIMEOUT + 6;
    localparam int NEVER    = 100000;

    logic                      clk_sys = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      start   = 1'b0;
    logic [CHANNELS-1:0]       sensor  = '1;
    logic                      busy;
    logic [CHANNELS-1:0]       done;
    logic [CHANNELS-1:0]       timeout_p;
    logic [CHANNELS*CNT_W-1:0] latency;
`ifdef LAG_METER_STATS_EN
    logic                           clear_stats = 1'b0;
    logic [CHANNELS*CNT_W-1:0]      lat_min;
    logic [CHANNELS*CNT_W-1:0]      lat_max;
    logic [CHANNELS*(CNT_W+16)-1:0] lat_sum;
    logic [CHANNELS*16-1:0]         lat_cnt;
    longint st_min [CHANNELS];
    longint st_max [CHANNELS];
    longint st_sum [CHANNELS];
    longint st_cnt [CHANNELS];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Active-level sensor trace per cycle (1 = light seen) and level before start.
    bit [CHANNELS-1:0] act_tr [0:MAXC];
    bit [CHANNELS-1:0] pre_act;
    longint            model_lat [CHANNELS];

    always #5 clk_sys = ~clk_sys;

    lag_meter #(
        .CHANNELS       (CHANNELS),
        .CNT_W          (CNT_W),
        .TIMEOUT        (TIMEOUT),
        .SENSOR_ACT_LOW (1'b1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .start       (start),
        .sensor      (sensor),
`ifdef LAG_METER_STATS_EN
        .clear_stats (clear_stats),
        .lat_min     (lat_min),
        .lat_max     (lat_max),
        .lat_sum     (lat_sum),
        .lat_cnt     (lat_cnt),
`endif
        .busy        (busy),
        .done        (done),
        .timeout     (timeout_p),
        .latency     (latency)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Channel trace: level lvl0 outside [t1,t2), opposite level inside it.
    task automatic set_ch(input int ch, input bit lvl0, input int t1, input int t2);
        pre_act[ch] = lvl0;
        for (int k = 0; k <= MAXC; k++)
            act_tr[k][ch] = (k < t1 || k >= t2) ? lvl0 : ~lvl0;
    endtask

    task automatic rand_trace();
        bit lvl;
        for (int c = 0; c < CHANNELS; c++) begin
            lvl = 1'($urandom_range(0, 1));
            pre_act[c] = lvl;
            for (int k = 0; k <= MAXC; k++) begin
                if ($urandom_range(0, 15) == 0) lvl = ~lvl;
                act_tr[k][c] = lvl;
            end
        end
    endtask

`ifdef LAG_METER_STATS_EN
    task automatic model_stats_clear();
        for (int c = 0; c < CHANNELS; c++) begin
            st_min[c] = (64'd1 << CNT_W) - 1;
            st_max[c] = 0;
            st_sum[c] = 0;
            st_cnt[c] = 0;
        end
    endtask

    task automatic check_stats();
        for (int c = 0; c < CHANNELS; c++) begin
            check("lat_min", lat_min[c*CNT_W +: CNT_W], st_min[c]);
            check("lat_max", lat_max[c*CNT_W +: CNT_W], st_max[c]);
            check("lat_sum", lat_sum[c*(CNT_W+16) +: (CNT_W+16)], st_sum[c]);
            check("lat_cnt", lat_cnt[c*16 +: 16], st_cnt[c]);
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk_sys); #1 clear_stats = 1'b1;
        @(posedge clk_sys); #1 clear_stats = 1'b0;
        model_stats_clear();
        @(negedge clk_sys);
        check_stats();
    endtask
`endif

    // One measurement: start in cycle 0, optional extra start, optional reset.
    task automatic run(input int extra_start, input int rst_cyc);
        bit [CHANNELS-1:0] cap_e;
        bit [CHANNELS-1:0] exp_done;
        bit [CHANNELS-1:0] exp_to;
        bit                prev_v;
        bit                exp_busy;
        longint            lat_e [CHANNELS];
        int                rep_e;
        int                lmax;

        // Reference: raw active in cycle j after inactive in j-1 -> latency j+2.
        cap_e = '0;
        lmax  = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            lat_e[c] = 0;
            for (int j = 0; j + 2 <= TIMEOUT; j++) begin
                prev_v = (j == 0) ? pre_act[c] : act_tr[j-1][c];
                if (!cap_e[c] && act_tr[j][c] && !prev_v) begin
                    cap_e[c] = 1'b1;
                    lat_e[c] = j + 2;
                    if (j + 2 > lmax) lmax = j + 2;
                end
            end
        end
        rep_e = (&cap_e) ? lmax + 1 : TIMEOUT + 1;
        if (rst_cyc >= 0) rep_e = -1;

        // Settle synchronisers on the pre-start level.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_sys); #1;
            start  = 1'b0;
            sensor = ~pre_act;
        end

        for (int k = 0; k <= MAXC; k++) begin
            @(posedge clk_sys); #1;
            start   = (k == 0) || (k == extra_start);
            sensor  = ~act_tr[k];
            reset_n = (k == rst_cyc) ? 1'b0 : 1'b1;
            @(negedge clk_sys);
            exp_busy = (rst_cyc >= 0) ? (k >= 1 && k < rst_cyc) : (k >= 1 && k <= rep_e);
            exp_done = (k == rep_e) ? cap_e : '0;
            exp_to   = (k == rep_e) ? ~cap_e : '0;
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("timeout", timeout_p, exp_to);
        end
        @(posedge clk_sys); #1 start = 1'b0; reset_n = 1'b1;

        for (int c = 0; c < CHANNELS; c++) begin
            if (rst_cyc >= 0) model_lat[c] = 0;
            else if (cap_e[c]) model_lat[c] = lat_e[c];
        end
`ifdef LAG_METER_STATS_EN
        if (rst_cyc >= 0) model_stats_clear();
        else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cap_e[c] && st_cnt[c] < 65535) begin
                    if (lat_e[c] < st_min[c]) st_min[c] = lat_e[c];
                    if (lat_e[c] > st_max[c]) st_max[c] = lat_e[c];
                    st_sum[c] = st_sum[c] + lat_e[c];
                    st_cnt[c] = st_cnt[c] + 1;
                end
            end
        end
`endif
        @(negedge clk_sys);
        for (int c = 0; c < CHANNELS; c++)
            check("latency", latency[c*CNT_W +: CNT_W], model_lat[c]);
`ifdef LAG_METER_STATS_EN
        check_stats();
`endif
    endtask

    initial begin
        for (int c = 0; c < CHANNELS; c++) model_lat[c] = 0;
`ifdef LAG_METER_STATS_EN
        model_stats_clear();
`endif
        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout_p, 0);
        check("rst_latency", latency, 0);
`ifdef LAG_METER_STATS_EN
        check_stats();
`endif
        @(posedge clk_sys); #1 reset_n = 1'b1;

        // Both channels captured: 12 and 22, report in cycle 23.
        set_ch(0, 1'b0, 10, NEVER);
        set_ch(1, 1'b0, 20, NEVER);
        run(-1, -1);
        check("basic_lat0", latency[0 +: CNT_W], 12);
        check("basic_lat1", latency[CNT_W +: CNT_W], 22);

        // Channel 1 silent: timeout after counter reaches TIMEOUT.
        set_ch(0, 1'b0, 5, NEVER);
        set_ch(1, 1'b0, NEVER, NEVER);
        run(-1, -1);
        check("tmo_lat0", latency[0 +: CNT_W], 7);

        // Sensor already active at start must cycle inactive/active first.
        set_ch(0, 1'b1, 30, 40);
        set_ch(1, 1'b0, 20, NEVER);
        run(-1, -1);
        check("preact_lat0", latency[0 +: CNT_W], 42);

        // Second start mid-measurement is ignored.
        set_ch(0, 1'b0, 10, NEVER);
        set_ch(1, 1'b0, 20, NEVER);
        run(15, -1);
        check("restart_lat0", latency[0 +: CNT_W], 12);
        check("restart_lat1", latency[CNT_W +: CNT_W], 22);

        // Reset mid-measurement aborts silently, then a normal run follows.
        run(-1, 8);
        check("abort_latency", latency, 0);
        run(-1, -1);

`ifdef LAG_METER_STATS_EN
        pulse_clear();
        set_ch(0, 1'b0, 10, NEVER); set_ch(1, 1'b0, 10, NEVER); run(-1, -1);
        set_ch(0, 1'b0, 28, NEVER); set_ch(1, 1'b0, 28, NEVER); run(-1, -1);
        set_ch(0, 1'b0, 16, NEVER); set_ch(1, 1'b0, 16, NEVER); run(-1, -1);
        check("stats_min0", lat_min[0 +: CNT_W], 12);
        check("stats_max0", lat_max[0 +: CNT_W], 30);
        check("stats_sum0", lat_sum[0 +: CNT_W+16], 60);
        check("stats_cnt0", lat_cnt[0 +: 16], 3);
        pulse_clear();
`endif

        // Randomized traces.
        for (int r = 0; r < 10; r++) begin
            rand_trace();
            run(-1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lag_meter.md
LAG_METER -- requirements
Module: lag_meter

Interface
REQ-001 Parameter CHANNELS, default 2, number of sensor inputs (1..7).
REQ-002 Parameter CNT_W, default 24, latency counter width.
REQ-003 Parameter TIMEOUT, default 2**CNT_W-1, cycle count after which a measurement aborts.
REQ-004 Parameter SENSOR_ACT_LOW, default 1, sensor active level is 0 (open-drain user port).
REQ-005 clk_sys  in  1  sole clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle pulse marking stimulus (flash) onset.
REQ-008 sensor  in  CHANNELS  raw asynchronous photosensor inputs.
REQ-009 busy  out  1  high while a measurement is in progress.
REQ-010 done  out  CHANNELS  one-cycle pulse per channel with a valid latency.
REQ-011 timeout  out  CHANNELS  one-cycle pulse per channel that saw no edge.
REQ-012 latency  out  CHANNELS*CNT_W  per-channel result, channel i at [i*CNT_W +: CNT_W], held until overwritten.

Function
REQ-013 FSM states IDLE, MEASURE, REPORT.
REQ-014 IDLE: start=1 -> MEASURE; counter cleared; all capture flags cleared.
REQ-015 Counter is k in the k-th cycle after the start cycle (start cycle = 0); increments by 1 per cycle and never wraps.
REQ-016 Each sensor passes a 2-flop synchroniser, then an inactive-to-active edge detector.
REQ-017 Raw sensor first sampled active in cycle j yields latency = j+2.
REQ-018 Sensor already active at start is not captured until it goes inactive and active again.
REQ-019 MEASURE: first detected edge on an uncaptured channel latches counter into latency[i] and sets its capture flag; later edges on that channel are ignored.
REQ-020 MEASURE -> REPORT when all channels are captured, or when counter = TIMEOUT, whichever comes first; simultaneous edge and timeout in the same cycle counts as captured.
REQ-021 REPORT lasts exactly one cycle: done[i]=captured[i], timeout[i]=~captured[i]; then -> IDLE.
REQ-022 start during MEASURE or REPORT is ignored; no restart.
REQ-023 busy = 1 in MEASURE and REPORT, 0 in IDLE.

Reset
REQ-024 reset_n low -> state IDLE, counter 0, capture flags 0, synchronisers 0, done/timeout/busy 0, latency 0, statistics per REQ-027.
REQ-025 Reset asserted mid-measurement aborts it with no done/timeout pulse.

Configuration
REQ-026 Macro LAG_METER_STATS_EN adds input clear_stats (1) and outputs lat_min, lat_max (CHANNELS*CNT_W), lat_sum (CHANNELS*(CNT_W+16)), lat_cnt (CHANNELS*16).
REQ-027 With LAG_METER_STATS_EN: in REPORT, each captured channel updates min, max, sum and count; count saturates at 65535, after which all four freeze; reset or clear_stats sets min all-ones, max/sum/count 0; clear_stats in the REPORT cycle wins over the update.
REQ-028 Without LAG_METER_STATS_EN: those ports and registers do not exist; all other behaviour is identical.

Structure
REQ-029 Package lag_meter_pkg holds the state enum and the synchroniser depth constant (2).
REQ-030 Sub-module lag_meter_sync: one instance per channel, containing the synchroniser, polarity normalisation and edge detect.

Verification
REQ-031 CHANNELS=2. Start at cycle 0; sensor0 active from cycle 10; sensor1 active from cycle 20 -> REPORT at cycle 23; done=2'b11; latency0=12, latency1=22.
REQ-032 TIMEOUT=100. Only sensor0 toggles, active at cycle 5 -> REPORT after counter=100; done=2'b01, timeout=2'b10, latency0=7.
REQ-033 Sensor0 held active before start, released at cycle 30, re-asserted at cycle 40 -> latency0=42.
REQ-034 Second start at cycle 15 of a measurement -> ignored; results match the single-start run.
REQ-035 reset_n pulsed low at cycle 8 of a measurement -> busy=0, no pulses, latency=0; next start measures normally.
REQ-036 Stats build: three runs with latency 12, 30, 18 -> min 12, max 30, sum 60, cnt 3; clear_stats -> min all-ones, others 0.
